dac80004_scheduler: RTL and testbench
=====================================

# dac80004_scheduler

Round-robin command scheduler that shares one `spi_master` (DWIDTH=32, CPOL=1) between the four channel-update requesters of a TI DAC80004 on the MALDI mapping stage. Host logic writes 16-bit channel codes at any time. The block marks each written channel pending, sends a one-time init word after reset, then turns each pending channel into a 32-bit DAC80004 command. It drives the `spi_master` tx_valid level handshake, captures the readback word and detects a stalled transfer.

## Interface
Parameters:
- `INIT_WORD`, default 32'h0400_000F: frame sent once after reset (power-up of all channels).
- `CMD`, default 4'h3: command nibble for channel updates (write-and-update).
- `GAP_CYCLES`, default 4: idle clk cycles with tx_valid low between frames. Legal range is 2 and up. It must also cover at least 2 sclk periods.
- `TIMEOUT`, default 4096: clk cycles allowed between raising tx_valid and receiving rx_valid.

Ports:
- `clk` in 1: single clock; the same clk that drives `spi_master`.
- `reset_n` in 1: reset is synchronous and active-low.
- `wr_en` in 1: one-cycle strobe that writes a channel code.
- `wr_ch` in 2: channel index 0..3.
- `wr_data` in 16: DAC code.
- `spi_tx_valid` out 1: connects to `spi_master.tx_valid`.
- `spi_tx_data` out 32: connects to `spi_master.tx_data`.
- `spi_rx_valid` in 1: connects to `spi_master.rx_valid`; a one-clk completion pulse.
- `spi_rx_data` in 32: connects to `spi_master.rx_data`.
- `pending` out 4: per-channel "write not yet issued" flags.
- `busy` out 1: high in every state except IDLE.
- `init_done` out 1: set when the init frame completes or times out.
- `last_rx` out 32: rx_data captured at the last completion.
- `timeout_err` out 1: sticky error flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- Reset values:
  - State is INIT_ISSUE.
  - `spi_tx_valid`, `spi_tx_data`, `pending`, `init_done`, `last_rx` and `timeout_err` are all 0.
  - `busy` is 1.
  - `rr_last` is 3, so channel 0 has first priority.
  - All four code registers are 0.
- Writes:
  - A `wr_en` strobe stores `wr_data` in `code[wr_ch]` and sets `pending[wr_ch]`.
  - Writes are accepted in every state, including during init.
  - Repeated writes before issue coalesce; the last value wins.
- Frame format: {4'h0, CMD, 2'b00, ch[1:0], code[ch][15:0], 4'h0}.
- State INIT_ISSUE:
  - Load `spi_tx_data` = `INIT_WORD`.
  - Set `spi_tx_valid` = 1.
  - Go to WAIT.
- State IDLE (reached only once `init_done` = 1):
  - If any bit of `pending` is set, select the first pending channel in the order `rr_last`+1, +2, +3, +4 (mod 4).
  - In the same cycle: load the frame using the code value as of that cycle, clear `pending[ch]`, set `rr_last` = ch, set `spi_tx_valid` = 1, and go to WAIT.
- State WAIT:
  - Hold `spi_tx_valid` and `spi_tx_data` stable.
  - Count cycles from the entry cycle.
  - On `spi_rx_valid`: set `last_rx` = `spi_rx_data`, set `spi_tx_valid` = 0, set `init_done` = 1 if the frame was the init frame, then go to GAP.
  - When the count reaches `TIMEOUT` with no `spi_rx_valid`: set `spi_tx_valid` = 0, set `timeout_err` = 1, set `init_done` = 1 if the frame was the init frame, then go to GAP. The frame is dropped and `pending` is not re-set.
- State GAP: wait `GAP_CYCLES` cycles, then go to IDLE.
- Collisions:
  - A write to the channel being cleared in the IDLE issue cycle leaves that `pending` bit set. The write wins; the frame carries the old code and a new frame follows.
  - A write to the in-flight channel during WAIT or GAP sets `pending` again.
  - `spi_rx_valid` outside WAIT is ignored.
  - `err_clr` and a new timeout in the same cycle leave `timeout_err` = 1 (set wins).
- Reset mid-frame: `spi_tx_valid` drops on the next clk edge and the sequence restarts at INIT_ISSUE. Pending writes are lost.

## Timing
- `wr_en` in cycle N makes `pending` visible in N+1.
- Issue latency: if IDLE sees `pending` != 0 in cycle N, `spi_tx_valid` rises in N+1.
- Completion: `spi_rx_valid` in cycle M makes `spi_tx_valid` = 0 and `last_rx` valid in M+1. The next rise of `spi_tx_valid` is no earlier than M+1+`GAP_CYCLES`+1.
- Timeout: `spi_tx_valid` falls exactly `TIMEOUT`+1 cycles after it rose.
- Width rules:
  - Timeout counter is $clog2(TIMEOUT+1) bits and saturates.
  - Gap counter is $clog2(GAP_CYCLES+1) bits.
  - `rr_last` is 2 bits and wraps modulo 4.
- `spi_tx_valid` stays low for at least `GAP_CYCLES` cycles between frames, so every frame presents a fresh 0->1 edge to `spi_master`.

## Test plan
- Reset, then a model that returns `spi_rx_valid` 40 cycles after each tx_valid rise with rx_data 32'hA5A5_0001 -> first frame is 32'h0400_000F, `init_done` goes to 1, `last_rx` = 32'hA5A5_0001, and `spi_tx_valid` is low for at least 4 cycles after completion.
- After init, write ch2 = 16'h1234 -> frame 32'h0320_1234... is wrong; the required frame is 32'h0321_2340, `pending` returns to 0, and `busy` drops after GAP.
- Write ch0..ch3 in consecutive cycles -> frames go out in channel order 0,1,2,3. Then write ch1 and ch0 together pending with `rr_last` = 3 -> ch0 is issued first.
- Write ch1 = 16'h0001 in the cycle ch1 is issued, then write 16'h0002 during WAIT -> two further ch1 frames are not produced; exactly one follow-up frame is sent, carrying 16'h0002.
- Model never asserts `spi_rx_valid` -> `spi_tx_valid` falls after 4097 cycles, `timeout_err` = 1 and `init_done` = 1. Pulse `err_clr` -> `timeout_err` = 0.
- Assert `reset_n` = 0 for one cycle during WAIT -> `spi_tx_valid` = 0 and `pending` = 0 on the next cycle, and the init frame is re-sent.

Source files
------------

// File: rtl/dac80004_scheduler.sv
// dac80004_scheduler: round-robin DAC80004 channel-update scheduler driving one spi_master
//   clk, reset_n      : clock, synchronous active-low reset
//   wr_en/wr_ch/wr_data : host strobe writing a 16-bit code to channel wr_ch
//   spi_tx_valid/data : level handshake and frame to spi_master
//   spi_rx_valid/data : completion pulse and readback word from spi_master
//   pending, busy     : per-channel unissued flags, high outside IDLE
//   init_done         : init frame finished (completed or timed out)
//   last_rx           : readback word of the last completed frame
//   timeout_err/err_clr : sticky stall flag and its clear
module dac80004_scheduler #(
   parameter logic [31:0] INIT_WORD  = 32'h0400_000F,
   parameter logic [3:0]  CMD        = 4'h3,
   parameter int          GAP_CYCLES = 4,
   parameter int          TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_ch,
   input  logic [15:0] wr_data,
   output logic        spi_tx_valid,
   output logic [31:0] spi_tx_data,
   input  logic        spi_rx_valid,
   input  logic [31:0] spi_rx_data,
   output logic [3:0]  pending,
   output logic        busy,
   output logic        init_done,
   output logic [31:0] last_rx,
   output logic        timeout_err,
   input  logic        err_clr
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {INIT_ISSUE, IDLE, WAIT, GAP} state_t;
   state_t state;
   logic [15:0] code [4];
   logic [1:0] rr_last, sel;
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;
   logic is_init, issue;
   assign busy = state != IDLE;
   assign issue = state == IDLE && |pending;
   // scan from the farthest candidate back so the nearest pending channel after rr_last wins
   always_comb begin
      sel = rr_last;
      for (int i = 4; i > 0; i--)
         if (pending[rr_last + 2'(i)]) sel = rr_last + 2'(i);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= INIT_ISSUE;
         spi_tx_valid <= 1'b0;
         spi_tx_data <= '0;
         pending <= '0;
         init_done <= 1'b0;
         last_rx <= '0;
         timeout_err <= 1'b0;
         rr_last <= 2'd3;
         tcnt <= '0;
         gcnt <= '0;
         is_init <= 1'b0;
         for (int i = 0; i < 4; i++) code[i] <= '0;
      end else begin
         // a same-cycle write re-sets the bit being cleared by the issue
         pending <= (pending & ~(issue ? 4'd1 << sel : 4'd0)) | (wr_en ? 4'd1 << wr_ch : 4'd0);
         if (wr_en) code[wr_ch] <= wr_data;
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            INIT_ISSUE: begin
               spi_tx_data <= INIT_WORD;
               spi_tx_valid <= 1'b1;
               is_init <= 1'b1;
               tcnt <= '0;
               state <= WAIT;
            end
            IDLE: if (issue) begin
               spi_tx_data <= {4'h0, CMD, 2'b00, sel, code[sel], 4'h0};
               spi_tx_valid <= 1'b1;
               rr_last <= sel;
               is_init <= 1'b0;
               tcnt <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (spi_rx_valid) begin
                  last_rx <= spi_rx_data;
                  spi_tx_valid <= 1'b0;
                  if (is_init) init_done <= 1'b1;
                  gcnt <= '0;
                  state <= GAP;
               end else if (tcnt == TW'(TIMEOUT)) begin
                  spi_tx_valid <= 1'b0;
                  timeout_err <= 1'b1;
                  if (is_init) init_done <= 1'b1;
                  gcnt <= '0;
                  state <= GAP;
               end else tcnt <= tcnt + 1'b1;
            end
            GAP: begin
               if (gcnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
               else gcnt <= gcnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dac80004_scheduler.sv
// tb_dac80004_scheduler: self-checking bench for dac80004_scheduler with an spi_master responder
module tb_dac80004_scheduler;
   logic clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, err_clr = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [15:0] wr_data = '0;
   logic spi_tx_valid, spi_rx_valid, busy, init_done, timeout_err;
   logic [31:0] spi_tx_data, spi_rx_data, last_rx;
   logic [3:0] pending;
   int checks = 0, errors = 0;
   logic [31:0] frames [$];
   bit resp_en = 1'b1, tx_prev = 1'b0, seen_frame = 1'b0;
   logic [31:0] rx_word = 32'hA5A5_0001;
   int rcnt = 0, hi_cnt = 0, hi_len = 0, lo_cnt = 0, min_gap = 1000;
   typedef struct {
      logic [1:0]  ch;
      logic [15:0] data;
      logic [3:0]  pend;
      logic [31:0] frame;
   } vec_t;
   vec_t vec [5];
   logic [31:0] burst_exp [4];
   dac80004_scheduler dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data),
      .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
      .pending(pending), .busy(busy), .init_done(init_done), .last_rx(last_rx),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );
   always #5 clk = ~clk;
   // spi_master stand-in: logs each frame on its tx_valid rise, answers 40 cycles later
   initial begin
      spi_rx_valid = 1'b0;
      spi_rx_data = '0;
      forever begin
         @(negedge clk);
         spi_rx_valid = 1'b0;
         if (spi_tx_valid && !tx_prev) begin
            frames.push_back(spi_tx_data);
            if (seen_frame && lo_cnt < min_gap) min_gap = lo_cnt;
            seen_frame = 1'b1;
            rcnt = 40;
            hi_cnt = 0;
         end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0 && resp_en) begin
               spi_rx_valid = 1'b1;
               spi_rx_data = rx_word;
            end
         end
         if (spi_tx_valid) hi_cnt++;
         if (!spi_tx_valid && tx_prev) hi_len = hi_cnt;
         lo_cnt = spi_tx_valid ? 0 : lo_cnt + 1;
         tx_prev = spi_tx_valid;
      end
   end
   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask
   task automatic write(input logic [1:0] ch, input logic [15:0] data);
      wr_en = 1'b1;
      wr_ch = ch;
      wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask
   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((busy || pending != 4'd0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s idle wait got %0d cycles expected under %0d", name, n, budget);
      end
   endtask
   function automatic logic [31:0] pop();
      if (frames.size() == 0) return 32'hDEAD_DEAD;
      return frames.pop_front();
   endfunction
   initial begin
      vec[0] = '{2'd2, 16'h1234, 4'b0100, 32'h0321_2340};
      vec[1] = '{2'd0, 16'hFFFF, 4'b0001, 32'h030F_FFF0};
      vec[2] = '{2'd1, 16'h0001, 4'b0010, 32'h0310_0010};
      vec[3] = '{2'd3, 16'hABCD, 4'b1000, 32'h033A_BCD0};
      vec[4] = '{2'd2, 16'h0000, 4'b0100, 32'h0320_0000};
      burst_exp[0] = 32'h0301_0000;
      burst_exp[1] = 32'h0311_0010;
      burst_exp[2] = 32'h0321_0020;
      burst_exp[3] = 32'h0331_0030;
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", {31'b0, spi_tx_valid}, 32'd0);
      chk("rst_tx_data", spi_tx_data, 32'd0);
      chk("rst_pending", {28'b0, pending}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_init_done", {31'b0, init_done}, 32'd0);
      chk("rst_last_rx", last_rx, 32'd0);
      chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
      reset_n = 1'b1;
      wait_idle("init", 500);
      chk("init_frames", 32'(frames.size()), 32'd1);
      chk("init_frame", pop(), 32'h0400_000F);
      chk("init_done", {31'b0, init_done}, 32'd1);
      chk("init_last_rx", last_rx, 32'hA5A5_0001);
      chk("init_timeout_err", {31'b0, timeout_err}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         frames.delete();
         write(vec[i].ch, vec[i].data);
         chk($sformatf("vec%0d_pending", i), {28'b0, pending}, {28'b0, vec[i].pend});
         wait_idle($sformatf("vec%0d", i), 500);
         chk($sformatf("vec%0d_frames", i), 32'(frames.size()), 32'd1);
         chk($sformatf("vec%0d_frame", i), pop(), vec[i].frame);
      end
      chk("vec_busy", {31'b0, busy}, 32'd0);
      frames.delete();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_ch = 2'(i);
         wr_data = 16'h1000 + 16'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_idle("burst", 1000);
      chk("burst_frames", 32'(frames.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("burst%0d", i), pop(), burst_exp[i]);
      frames.delete();
      write(2'd3, 16'h0003);
      repeat (5) @(negedge clk);
      write(2'd1, 16'h0011);
      write(2'd0, 16'h0010);
      chk("rr_pending", {28'b0, pending}, 32'h3);
      wait_idle("rr", 1000);
      chk("rr_frames", 32'(frames.size()), 32'd3);
      chk("rr_first", pop(), 32'h0330_0030);
      chk("rr_ch0", pop(), 32'h0300_0100);
      chk("rr_ch1", pop(), 32'h0310_0110);
      frames.delete();
      wr_en = 1'b1;
      wr_ch = 2'd1;
      wr_data = 16'h00AA;
      @(negedge clk);
      wr_data = 16'h0001;
      @(negedge clk);
      wr_en = 1'b0;
      chk("coll_pending", {28'b0, pending}, 32'h2);
      chk("coll_tx_valid", {31'b0, spi_tx_valid}, 32'd1);
      chk("coll_tx_data", spi_tx_data, 32'h0310_0AA0);
      repeat (5) @(negedge clk);
      write(2'd1, 16'h0002);
      wait_idle("coll", 1000);
      chk("coll_frames", 32'(frames.size()), 32'd2);
      chk("coll_first", pop(), 32'h0310_0AA0);
      chk("coll_second", pop(), 32'h0310_0020);
      chk("min_gap_ok", {31'b0, min_gap >= 4}, 32'd1);
      frames.delete();
      resp_en = 1'b0;
      write(2'd0, 16'h5555);
      wait_idle("timeout", 6000);
      chk("to_frame", pop(), 32'h0305_5550);
      chk("to_high_len", 32'(hi_len), 32'd4097);
      chk("to_err", {31'b0, timeout_err}, 32'd1);
      chk("to_pending", {28'b0, pending}, 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr", {31'b0, timeout_err}, 32'd0);
      resp_en = 1'b1;
      write(2'd2, 16'h7777);
      repeat (5) @(negedge clk);
      write(2'd3, 16'h1111);
      chk("mid_pending", {28'b0, pending}, 32'h8);
      reset_n = 1'b0;
      resp_en = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx_valid", {31'b0, spi_tx_valid}, 32'd0);
      chk("mid_rst_pending", {28'b0, pending}, 32'd0);
      chk("mid_rst_init_done", {31'b0, init_done}, 32'd0);
      chk("mid_rst_last_rx", last_rx, 32'd0);
      frames.delete();
      reset_n = 1'b1;
      wait_idle("reinit", 6000);
      chk("reinit_frames", 32'(frames.size()), 32'd1);
      chk("reinit_frame", pop(), 32'h0400_000F);
      chk("reinit_high_len", 32'(hi_len), 32'd4097);
      chk("reinit_done", {31'b0, init_done}, 32'd1);
      chk("reinit_err", {31'b0, timeout_err}, 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
